// File: rtl/imem_access_arbiter.sv
// Two-port access sequencer for a single-port instruction memory.
// Port 0 is instruction fetch and port 1 is the loader/debug port.
// Each access runs IDLE -> ACCESS -> DONE with round-robin arbitration,
// range and alignment checking, and write protection sampled at grant.
module imem_access_arbiter #(
  parameter int DATA_SIZE    = 32,
  parameter int ADDRESS_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [31:0]          addr0,
  input  logic [DATA_SIZE-1:0] wdata0,
  output logic                 ack0,
  output logic                 err0,
  output logic [DATA_SIZE-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [31:0]          addr1,
  input  logic [DATA_SIZE-1:0] wdata1,
  output logic                 ack1,
  output logic                 err1,
  output logic [DATA_SIZE-1:0] rdata1,
  input  logic                 wp,
  output logic                 busy,
  output logic [31:0]          mem_address,
  output logic [DATA_SIZE-1:0] mem_data_in,
  output logic                 mem_write,
  input  logic [DATA_SIZE-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  // Port granted most recently; reset to 1 so port 0 wins the first tie.
  logic                   last_grant;

  // Access parameters captured at grant; stable through ACCESS and DONE.
  logic                   lat_id;
  logic                   lat_we;
  logic                   lat_err;
  logic [31:0]            lat_addr;
  logic [DATA_SIZE-1:0]   lat_wdata;

  // Grant decision for the current IDLE cycle.
  logic                   grant;
  logic                   grant_id;
  logic                   grant_we;
  logic                   grant_err;
  logic [31:0]            grant_addr;
  logic [DATA_SIZE-1:0]   grant_wdata;

  // Value a completing access returns on its rdata port.
  logic [DATA_SIZE-1:0]   rd_value;

  // Next-state, arbitration and error classification of the candidate access.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          // On a tie the port that did not win last time goes first.
          if (req0 && req1) grant_id = ~last_grant;
          else              grant_id = req1;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    grant_we    = grant_id ? we1    : we0;
    grant_addr  = grant_id ? addr1  : addr0;
    grant_wdata = grant_id ? wdata1 : wdata0;
    // Misaligned, beyond the memory depth, or a write while protected.
    grant_err   = (grant_addr[1:0] != 2'b00)
                || (grant_addr[31:ADDRESS_SIZE+2] != '0)
                || (grant_we && wp);
  end

  // State register and capture of the granted access.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_we     <= grant_we;
        lat_err    <= grant_err;
        lat_addr   <= grant_addr;
        lat_wdata  <= grant_wdata;
      end
    end
  end

  // Writes and errors complete with zero read data.
  assign rd_value = (lat_we || lat_err) ? '0 : mem_data_out;

  // Per-port read data, updated only on the edge that ends the winner's ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (state == ACCESS) begin
      if (lat_id) rdata1 <= rd_value;
      else        rdata0 <= rd_value;
    end
  end

  // The latched address and data only change at grant, so the memory bus
  // holds its last values outside ACCESS. The write strobe decodes straight
  // from the state register so an asynchronous reset drops it immediately.
  assign mem_address = lat_addr;
  assign mem_data_in = lat_wdata;
  assign mem_write   = (state == ACCESS) && lat_we && !lat_err;

  assign busy = (state != IDLE);
  assign ack0 = (state == DONE) && !lat_id;
  assign ack1 = (state == DONE) &&  lat_id;
  assign err0 = ack0 && lat_err;
  assign err1 = ack1 && lat_err;

endmodule
